pb_conditioner: RTL
===================

Name: pb_conditioner

Overview:
Parametrised N-channel push-button conditioner that sits between the raw board buttons (pb_a, pb_b, pb_op and future additions) and the ALU_TOP input-capture logic.
- Per channel: synchronises the raw input, debounces it with a stable-count filter, and emits a clean level plus single-cycle press and release pulses.
- Optional per-channel auto-repeat while a button is held, for stepping operand values without re-pressing.

Parameters:
N_CH, 3, number of independent button channels.
SYNC_STAGES, 2, synchroniser flop depth per channel (legal values 2 or more).
STABLE_CYCLES, 16, number of consecutive synchronised samples that must differ from the current level before the level flips (legal values 2 or more).
REPEAT_DELAY, 32, cycles from pb_press to the first pb_repeat pulse (legal values 1 or more).
REPEAT_PERIOD, 8, cycles between later pb_repeat pulses (legal values 1 or more).
CNT_W, 16, width of the per-channel debounce counter and repeat counter; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
Clk  input  1  system clock (50 MHz on board), all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
pb_raw  input  N_CH  raw, asynchronous, bouncing button inputs, active-high.
repeat_en  input  N_CH  per-channel auto-repeat enable, synchronous to Clk.
pb_level  output  N_CH  debounced button level, registered.
pb_press  output  N_CH  one-cycle pulse when pb_level goes 0 to 1.
pb_release  output  N_CH  one-cycle pulse when pb_level goes 1 to 0.
pb_repeat  output  N_CH  one-cycle auto-repeat pulse while held.
pb_any  output  1  OR of pb_press and pb_repeat across all channels, registered alongside them.

Behaviour:
- Reset (async, active-high): all synchroniser flops, counters and outputs go to 0; repeat FSM goes to IDLE. Outputs stay 0 until the first debounced change after reset deasserts.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- Synchroniser: SYNC_STAGES flop chain per channel. Only the last stage (sync_q) feeds the filter.
- Debounce filter, per channel:
  - If sync_q equals pb_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter is at STABLE_CYCLES-1 and sync_q still differs, pb_level toggles and the counter clears.
  - Any single disagreeing sample (a bounce) restarts the count.
- Latency: pb_level changes exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge at which pb_raw is sampled at its new value, provided it stays constant.
- pb_press and pb_release are registered in the same edge as the pb_level change; each is high for exactly one cycle.
- Repeat FSM, per channel, states IDLE, HOLD_WAIT, REPEATING:
  - IDLE: on the press event with repeat_en=1, go to HOLD_WAIT and load the repeat counter.
  - HOLD_WAIT: pulse pb_repeat REPEAT_DELAY cycles after the pb_press cycle, then go to REPEATING.
  - REPEATING: pulse pb_repeat every REPEAT_PERIOD cycles.
  - From any state, a release event returns the FSM to IDLE in the same edge.
  - repeat_en sampled low while in HOLD_WAIT or REPEATING goes to IDLE with no further pulses; re-raising repeat_en does not restart repeats until the next press.
  - pb_repeat never coincides with pb_press on the same channel.
- pb_any is high in a cycle where any channel's pb_press or pb_repeat is high.
- Reset mid-hold: all state is cleared and no release pulse is produced. If the button is still held after reset deasserts, a fresh press is detected after the normal latency.

Test Plan:
1. Reset held 10 cycles, pb_raw=000 -> all outputs 0 during and after reset.
2. Bounce: channel 0 toggled every cycle for 30 cycles, then held high 27 cycles -> no pulse during the bounce; exactly one pb_press[0] 18 cycles after the stable-high start; pb_level[0]=1; pb_release=0.
3. Glitch rejection: pb_raw[1] high for 15 cycles, then low -> pb_level[1] stays 0; no pb_press.
4. Auto-repeat: repeat_en[2]=1, pb_raw[2] held high 100 cycles after press at cycle P -> pb_repeat[2] at P+32, P+40, …, P+88; release then yields pb_release[2] and no further repeats.
5. Simultaneous: pb_raw=111 set on the same edge -> pb_press=111 on the same cycle; pb_any=1 for that single cycle.
6. Reset mid-repeat: assert reset during REPEATING on channel 2 with the button held -> outputs 0 immediately, no pb_release; after deassert, pb_press[2] occurs 18 cycles later.

Source files
------------

// File: rtl/pb_if.sv
// Push-button conditioner bus: raw buttons and repeat enables in, conditioned level and pulses out.
interface pb_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] pb_raw;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] pb_press;
  logic [N_CH-1:0] pb_release;
  logic [N_CH-1:0] pb_repeat;
  logic            pb_any;

  modport master (
    output pb_raw, repeat_en,
    input  pb_level, pb_press, pb_release, pb_repeat, pb_any
  );

  modport slave (
    input  pb_raw, repeat_en,
    output pb_level, pb_press, pb_release, pb_repeat, pb_any
  );
endinterface

// File: rtl/pb_conditioner.sv
// N-channel push-button conditioner: synchroniser, stable-count debounce, press/release pulses
// and per-channel auto-repeat.
//
// Repeat FSM (one per channel):
//   state     | meaning
//   IDLE      | no repeat activity
//   HOLD_WAIT | held with repeat enabled, counting down the initial delay
//   REPEATING | held, pulsing pb_repeat every REPEAT_PERIOD cycles
module pb_conditioner #(
  parameter int N_CH          = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_DELAY  = 32,
  parameter int REPEAT_PERIOD = 8,
  parameter int CNT_W         = 16
) (
  input logic Clk,
  input logic reset,
  pb_if.slave bus
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD_WAIT = 2'd1;
  localparam logic [1:0] ST_REPEATING = 2'd2;

  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] release_v;
  logic [N_CH-1:0] repeat_v;
  logic [N_CH-1:0] press_d_v;
  logic [N_CH-1:0] repeat_d_v;
  logic            any_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic                   level_q;
    logic                   flip;
    logic                   press_d;
    logic                   release_d;
    logic                   press_q;
    logic                   release_q;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       rpt_cnt_q;
    logic [CNT_W-1:0]       rpt_cnt_d;
    logic                   rpt_d;
    logic                   rpt_q;

    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], bus.pb_raw[ch]};
      end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    // A single agreeing sample clears the count, so only an unbroken run flips the level.
    assign flip      = (sync_q != level_q) && (db_cnt == STABLE_TC);
    assign press_d   = flip && !level_q;
    assign release_d = flip && level_q;

    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync_q == level_q) begin
        db_cnt <= '0;
      end else if (flip) begin
        db_cnt  <= '0;
        level_q <= ~level_q;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_d     = 1'b0;
      if (release_d) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press_d && bus.repeat_en[ch]) begin
              state_d   = ST_HOLD_WAIT;
              rpt_cnt_d = DELAY_LD;
            end
          end
          ST_HOLD_WAIT, ST_REPEATING: begin
            if (!bus.repeat_en[ch]) begin
              state_d = ST_IDLE;
            end else if (rpt_cnt_q == '0) begin
              rpt_d     = 1'b1;
              state_d   = ST_REPEATING;
              rpt_cnt_d = PERIOD_LD;
            end else begin
              rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        rpt_q     <= rpt_d;
      end
    end

    assign level_v[ch]    = level_q;
    assign press_v[ch]    = press_q;
    assign release_v[ch]  = release_q;
    assign repeat_v[ch]   = rpt_q;
    assign press_d_v[ch]  = press_d;
    assign repeat_d_v[ch] = rpt_d;
  end

  // Built from the next-state pulses so pb_any lines up with the registered pulses.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |(press_d_v | repeat_d_v);
    end
  end

  assign bus.pb_level   = level_v;
  assign bus.pb_press   = press_v;
  assign bus.pb_release = release_v;
  assign bus.pb_repeat  = repeat_v;
  assign bus.pb_any     = any_q;

endmodule
